// File: rtl/spram_bank_ctrl_pkg.sv
// Shared constants, bank power-state type and small helpers for the
// multi-bank SPRAM data-memory controller.
package spram_bank_ctrl_pkg;

    localparam int SPRAM_AW  = 14;
    localparam int DATA_W    = 16;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        BANK_AWAKE  = 2'd0,
        BANK_SLEEP  = 2'd1,
        BANK_WAKING = 2'd2
    } bank_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // SB_SPRAM256KA write mask is per nibble: two mask bits per byte lane.
    function automatic logic [3:0] be_to_mask(input logic [1:0] be);
        return {be[1], be[1], be[0], be[0]};
    endfunction

    function automatic logic [DATA_W-1:0] mask_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [3:0]        mask);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) res[4*n +: 4] = new_w[4*n +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/spram_bank_ctrl_if.sv
// Two-port request/response bus of the SPRAM controller plus bank power status.
interface spram_bank_ctrl_if #(
    parameter int NUM_BANKS = 4
) ();
    import spram_bank_ctrl_pkg::*;

    localparam int ADDR_W = SPRAM_AW + clog2(NUM_BANKS);

    logic                 a_valid, a_ready, a_we, a_rvalid;
    logic [ADDR_W-1:0]    a_addr;
    logic [DATA_W-1:0]    a_wdata, a_rdata;
    logic [1:0]           a_be;
    logic                 b_valid, b_ready, b_we, b_rvalid;
    logic [ADDR_W-1:0]    b_addr;
    logic [DATA_W-1:0]    b_wdata, b_rdata;
    logic [1:0]           b_be;
    logic [NUM_BANKS-1:0] bank_awake;

    modport master (
        output a_valid, a_we, a_addr, a_wdata, a_be,
        output b_valid, b_we, b_addr, b_wdata, b_be,
        input  a_ready, a_rvalid, a_rdata,
        input  b_ready, b_rvalid, b_rdata,
        input  bank_awake
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata, a_be,
        input  b_valid, b_we, b_addr, b_wdata, b_be,
        output a_ready, a_rvalid, a_rdata,
        output b_ready, b_rvalid, b_rdata,
        output bank_awake
    );

endinterface

// File: rtl/spram_bank_ctrl_bank.sv
// One 16Kx16 SPRAM bank: the SPRAM macro plus its idle counter and
// AWAKE/SLEEP/WAKING power FSM.
module spram_bank_ctrl_bank
    import spram_bank_ctrl_pkg::*;
#(
    parameter int IDLE_SLEEP  = 1024,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic                i_cs,
    input  logic                i_we,
    input  logic [SPRAM_AW-1:0] i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [3:0]          i_mask,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_awake
);

    localparam int IDLE_W = (clog2(IDLE_SLEEP + 1) > 0) ? clog2(IDLE_SLEEP + 1) : 1;
    localparam int WAKE_W = (clog2(WAKE_CYCLES + 1) > 0) ? clog2(WAKE_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_SLEEP - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_SLEEP);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    bank_state_e       r_state, w_state_nxt;
    logic [IDLE_W-1:0] r_idle, w_idle_nxt;
    logic [WAKE_W-1:0] r_wake, w_wake_nxt;
    logic              w_sleep;

    // The wake-up request cycle already counts as the first wake cycle,
    // so SLEEP is released combinationally as soon as a request appears.
    assign w_sleep = (r_state == BANK_SLEEP) && !i_req;
    assign o_awake = (r_state == BANK_AWAKE);

    // Power FSM next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle;
        w_wake_nxt  = r_wake;
        case (r_state)
            BANK_AWAKE: begin
                if (i_cs || (IDLE_SLEEP == 0)) begin
                    w_idle_nxt = {IDLE_W{1'b0}};
                end else if (r_idle == IDLE_LAST) begin
                    w_state_nxt = BANK_SLEEP;
                    w_idle_nxt  = IDLE_MAX;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            BANK_SLEEP: begin
                if (!i_req) begin
                    w_state_nxt = BANK_SLEEP;
                end else if (WAKE_CYCLES <= 1) begin
                    w_state_nxt = BANK_AWAKE;
                    w_idle_nxt  = {IDLE_W{1'b0}};
                end else begin
                    w_state_nxt = BANK_WAKING;
                    w_wake_nxt  = WAKE_W'(1);
                end
            end
            BANK_WAKING: begin
                if (r_wake >= WAKE_LAST) begin
                    w_state_nxt = BANK_AWAKE;
                    w_idle_nxt  = {IDLE_W{1'b0}};
                    w_wake_nxt  = {WAKE_W{1'b0}};
                end else begin
                    w_wake_nxt = r_wake + 1'b1;
                end
            end
            default: begin
                w_state_nxt = BANK_AWAKE;
                w_idle_nxt  = {IDLE_W{1'b0}};
                w_wake_nxt  = {WAKE_W{1'b0}};
            end
        endcase
    end

    // Power FSM state and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BANK_AWAKE;
            r_idle  <= {IDLE_W{1'b0}};
            r_wake  <= {WAKE_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= w_idle_nxt;
            r_wake  <= w_wake_nxt;
        end
    end

`ifdef SYNTHESIS
    SB_SPRAM256KA u_spram (
        .ADDRESS    (i_addr),
        .DATAIN     (i_wdata),
        .MASKWREN   (i_mask),
        .WREN       (i_we),
        .CHIPSELECT (i_cs),
        .CLOCK      (clock),
        .STANDBY    (1'b0),
        .SLEEP      (w_sleep),
        .POWEROFF   (1'b1),
        .DATAOUT    (o_rdata)
    );
`else
    logic [DATA_W-1:0] r_mem [0:(1 << SPRAM_AW) - 1];
    logic [DATA_W-1:0] r_dout;

    // Behavioural SPRAM: registered read port, nibble-masked writes
    always_ff @(posedge clock) begin
        if (i_cs && !w_sleep) begin
            if (i_we) begin
                r_mem[i_addr] <= mask_merge(r_mem[i_addr], i_wdata, i_mask);
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_dout;
`endif

endmodule

// File: rtl/spram_bank_ctrl.sv
// Multi-bank SPRAM controller: address decode, per-bank arbitration between
// ports A and B, read-return routing and out-of-range handling.
module spram_bank_ctrl
    import spram_bank_ctrl_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int ARB_MODE    = 0,
    parameter int IDLE_SLEEP  = 1024,
    parameter int WAKE_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    spram_bank_ctrl_if.slave bus
);

    localparam int BANK_BITS = clog2(NUM_BANKS);
    localparam int ADDR_W    = SPRAM_AW + BANK_BITS;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int NBW       = BANK_W + 1;
    localparam logic [NBW-1:0] NB = NBW'(NUM_BANKS);

    logic [BANK_W-1:0]    w_a_bank, w_b_bank;
    logic                 w_a_oor, w_b_oor;
    logic [NUM_BANKS-1:0] w_a_hit, w_b_hit, w_a_gnt, w_b_gnt, w_b_first, w_awake;
    logic [DATA_W-1:0]    w_bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0]    w_a_rnew, w_b_rnew;
    logic [NUM_BANKS-1:0] r_rr_ptr;
    logic                 r_a_rvalid, r_b_rvalid, r_a_oor, r_b_oor;
    logic [BANK_W-1:0]    r_a_bank, r_b_bank;
    logic [DATA_W-1:0]    r_a_rdata, r_b_rdata;

    if (BANK_BITS > 0) begin : g_bank_decode
        assign w_a_bank = bus.a_addr[ADDR_W-1:SPRAM_AW];
        assign w_b_bank = bus.b_addr[ADDR_W-1:SPRAM_AW];
    end else begin : g_single_bank
        assign w_a_bank = {BANK_W{1'b0}};
        assign w_b_bank = {BANK_W{1'b0}};
    end

    // Out-of-range requests bypass the banks entirely.
    assign w_a_oor = ({1'b0, w_a_bank} >= NB);
    assign w_b_oor = ({1'b0, w_b_bank} >= NB);

    // Per-bank request decode and same-bank arbitration
    always_comb begin
        w_a_hit   = {NUM_BANKS{1'b0}};
        w_b_hit   = {NUM_BANKS{1'b0}};
        w_a_gnt   = {NUM_BANKS{1'b0}};
        w_b_gnt   = {NUM_BANKS{1'b0}};
        w_b_first = {NUM_BANKS{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_a_hit[b]   = reset_n && bus.a_valid && !w_a_oor && (w_a_bank == BANK_W'(b));
            w_b_hit[b]   = reset_n && bus.b_valid && !w_b_oor && (w_b_bank == BANK_W'(b));
            w_b_first[b] = (ARB_MODE == ARB_RR) && r_rr_ptr[b];
            w_a_gnt[b]   = w_awake[b] && w_a_hit[b] && (!w_b_hit[b] || !w_b_first[b]);
            w_b_gnt[b]   = w_awake[b] && w_b_hit[b] && (!w_a_hit[b] ||  w_b_first[b]);
        end
    end

    assign bus.a_ready    = reset_n && bus.a_valid && (w_a_oor || (|w_a_gnt));
    assign bus.b_ready    = reset_n && bus.b_valid && (w_b_oor || (|w_b_gnt));
    assign bus.bank_awake = w_awake;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        spram_bank_ctrl_bank #(
            .IDLE_SLEEP  (IDLE_SLEEP),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_bank (
            .clock   (clock),
            .reset_n (reset_n),
            .i_req   (w_a_hit[g] || w_b_hit[g]),
            .i_cs    (w_a_gnt[g] || w_b_gnt[g]),
            .i_we    (w_a_gnt[g] ? bus.a_we : bus.b_we),
            .i_addr  (w_a_gnt[g] ? bus.a_addr[SPRAM_AW-1:0] : bus.b_addr[SPRAM_AW-1:0]),
            .i_wdata (w_a_gnt[g] ? bus.a_wdata : bus.b_wdata),
            .i_mask  (be_to_mask(w_a_gnt[g] ? bus.a_be : bus.b_be)),
            .o_rdata (w_bank_rdata[g]),
            .o_awake (w_awake[g])
        );
    end

    // Fresh read data for the rvalid cycle, selected by the bank latched at accept
    always_comb begin
        w_a_rnew = {DATA_W{1'b0}};
        w_b_rnew = {DATA_W{1'b0}};
        if (r_a_oor) w_a_rnew = {DATA_W{1'b0}};
        else         w_a_rnew = w_bank_rdata[r_a_bank];
        if (r_b_oor) w_b_rnew = {DATA_W{1'b0}};
        else         w_b_rnew = w_bank_rdata[r_b_bank];
    end

    // Round-robin pointers flip only when a conflict is actually granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rr_ptr <= {NUM_BANKS{1'b0}};
        else          r_rr_ptr <= r_rr_ptr ^ (w_a_hit & w_b_hit & w_awake);
    end

    // Read-return tracking and rdata hold registers for both ports
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_oor    <= 1'b0;
            r_b_oor    <= 1'b0;
            r_a_bank   <= {BANK_W{1'b0}};
            r_b_bank   <= {BANK_W{1'b0}};
            r_a_rdata  <= {DATA_W{1'b0}};
            r_b_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_a_rvalid <= bus.a_ready && !bus.a_we;
            r_b_rvalid <= bus.b_ready && !bus.b_we;
            if (bus.a_ready && !bus.a_we) begin
                r_a_oor  <= w_a_oor;
                r_a_bank <= w_a_bank;
            end
            if (bus.b_ready && !bus.b_we) begin
                r_b_oor  <= w_b_oor;
                r_b_bank <= w_b_bank;
            end
            if (r_a_rvalid) r_a_rdata <= w_a_rnew;
            if (r_b_rvalid) r_b_rdata <= w_b_rnew;
        end
    end

    assign bus.a_rvalid = r_a_rvalid;
    assign bus.b_rvalid = r_b_rvalid;
    assign bus.a_rdata  = r_a_rvalid ? w_a_rnew : r_a_rdata;
    assign bus.b_rdata  = r_b_rvalid ? w_b_rnew : r_b_rdata;

endmodule

// File: tb/tb_spram_bank_ctrl.sv
// Directed bench for spram_bank_ctrl: three configurations share one stimulus
// bus, gated by sel (0: 4 banks fixed prio, 1: 4 banks round-robin, 2: 3 banks with sleep).
module tb_spram_bank_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  sel;
    logic        a_valid, a_we, b_valid, b_we;
    logic [15:0] a_addr, b_addr, a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    logic        a_rdy, b_rdy, a_rv, b_rv;
    logic [15:0] a_rd, b_rd;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 clock = ~clock;

    spram_bank_ctrl_if #(.NUM_BANKS(4)) if0 ();
    spram_bank_ctrl_if #(.NUM_BANKS(4)) if1 ();
    spram_bank_ctrl_if #(.NUM_BANKS(3)) if2 ();

    spram_bank_ctrl #(.NUM_BANKS(4), .ARB_MODE(0), .IDLE_SLEEP(0), .WAKE_CYCLES(4))
        dut0 (.clock(clock), .reset_n(reset_n), .bus(if0.slave));
    spram_bank_ctrl #(.NUM_BANKS(4), .ARB_MODE(1), .IDLE_SLEEP(0), .WAKE_CYCLES(4))
        dut1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));
    spram_bank_ctrl #(.NUM_BANKS(3), .ARB_MODE(0), .IDLE_SLEEP(8), .WAKE_CYCLES(4))
        dut2 (.clock(clock), .reset_n(reset_n), .bus(if2.slave));

    assign if0.a_valid = a_valid && (sel == 2'd0);
    assign if0.b_valid = b_valid && (sel == 2'd0);
    assign if1.a_valid = a_valid && (sel == 2'd1);
    assign if1.b_valid = b_valid && (sel == 2'd1);
    assign if2.a_valid = a_valid && (sel == 2'd2);
    assign if2.b_valid = b_valid && (sel == 2'd2);
    assign {if0.a_we, if0.a_addr, if0.a_wdata, if0.a_be} = {a_we, a_addr, a_wdata, a_be};
    assign {if0.b_we, if0.b_addr, if0.b_wdata, if0.b_be} = {b_we, b_addr, b_wdata, b_be};
    assign {if1.a_we, if1.a_addr, if1.a_wdata, if1.a_be} = {a_we, a_addr, a_wdata, a_be};
    assign {if1.b_we, if1.b_addr, if1.b_wdata, if1.b_be} = {b_we, b_addr, b_wdata, b_be};
    assign {if2.a_we, if2.a_addr, if2.a_wdata, if2.a_be} = {a_we, a_addr, a_wdata, a_be};
    assign {if2.b_we, if2.b_addr, if2.b_wdata, if2.b_be} = {b_we, b_addr, b_wdata, b_be};

    always_comb begin
        case (sel)
            2'd0: {a_rdy, b_rdy, a_rv, b_rv, a_rd, b_rd} =
                  {if0.a_ready, if0.b_ready, if0.a_rvalid, if0.b_rvalid, if0.a_rdata, if0.b_rdata};
            2'd1: {a_rdy, b_rdy, a_rv, b_rv, a_rd, b_rd} =
                  {if1.a_ready, if1.b_ready, if1.a_rvalid, if1.b_rvalid, if1.a_rdata, if1.b_rdata};
            2'd2: {a_rdy, b_rdy, a_rv, b_rv, a_rd, b_rd} =
                  {if2.a_ready, if2.b_ready, if2.a_rvalid, if2.b_rvalid, if2.a_rdata, if2.b_rdata};
            default: {a_rdy, b_rdy, a_rv, b_rv, a_rd, b_rd} = 36'd0;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setA(input logic v, input logic we, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be);
        a_valid = v; a_we = we; a_addr = addr; a_wdata = data; a_be = be;
    endtask

    task automatic setB(input logic v, input logic we, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be);
        b_valid = v; b_we = we; b_addr = addr; b_wdata = data; b_be = be;
    endtask

    // Check this cycle's ready pair, then advance to the next falling edge.
    task automatic go(input logic ea, input logic eb, input string tag);
        #1;
        check({tag, "_a_ready"}, {15'd0, a_rdy}, {15'd0, ea});
        check({tag, "_b_ready"}, {15'd0, b_rdy}, {15'd0, eb});
        @(negedge clock);
    endtask

    initial begin
        sel = 2'd0;
        reset_n = 1'b0;
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        setB(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        @(negedge clock);
        @(negedge clock);
        check("rst_a_rvalid", {15'd0, a_rv}, 16'd0);
        check("rst_a_rdata", a_rd, 16'h0000);
        check("rst_b_rdata", b_rd, 16'h0000);
        check("rst_awake4", {12'd0, if0.bank_awake}, 16'h000F);
        check("rst_awake3", {13'd0, if2.bank_awake}, 16'h0007);
        reset_n = 1'b1;

        // single-port write then read
        setA(1'b1, 1'b1, 16'h0005, 16'hBEEF, 2'b11); go(1'b1, 1'b0, "wr");
        check("wr_no_rvalid", {15'd0, a_rv}, 16'd0);
        setA(1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00); go(1'b1, 1'b0, "rd");
        setA(1'b0, 1'b0, 16'h0005, 16'h0000, 2'b00);
        check("rd_rvalid", {15'd0, a_rv}, 16'd1);
        check("rd_data", a_rd, 16'hBEEF);
        check("rd_b_idle", {15'd0, b_rv}, 16'd0);
        @(negedge clock);
        check("rvalid_pulse", {15'd0, a_rv}, 16'd0);
        check("rdata_hold", a_rd, 16'hBEEF);

        // byte enables
        setA(1'b1, 1'b1, 16'h0006, 16'hFFFF, 2'b11); go(1'b1, 1'b0, "be_full");
        setA(1'b1, 1'b1, 16'h0006, 16'h1234, 2'b01); go(1'b1, 1'b0, "be_lo");
        setA(1'b1, 1'b0, 16'h0006, 16'h0000, 2'b00); go(1'b1, 1'b0, "be_rd");
        check("be_lo_data", a_rd, 16'hFF34);
        setA(1'b1, 1'b1, 16'h0006, 16'h0000, 2'b00); go(1'b1, 1'b0, "be_none");
        setA(1'b1, 1'b0, 16'h0006, 16'h0000, 2'b00); go(1'b1, 1'b0, "be_rd2");
        check("be_none_data", a_rd, 16'hFF34);

        // parallel banks 0 and 1
        setA(1'b1, 1'b1, 16'h0010, 16'h1111, 2'b11);
        setB(1'b1, 1'b1, 16'h4010, 16'h2222, 2'b11); go(1'b1, 1'b1, "par_wr");
        setA(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        setB(1'b1, 1'b0, 16'h4010, 16'h0000, 2'b00); go(1'b1, 1'b1, "par_rd");
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        setB(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        check("par_a_rvalid", {15'd0, a_rv}, 16'd1);
        check("par_b_rvalid", {15'd0, b_rv}, 16'd1);
        check("par_a_data", a_rd, 16'h1111);
        check("par_b_data", b_rd, 16'h2222);

        // conflict on bank 2, fixed priority
        setA(1'b1, 1'b0, 16'h8000, 16'h0000, 2'b00);
        setB(1'b1, 1'b0, 16'h8004, 16'h0000, 2'b00);
        for (int i = 0; i < 4; i++) go(1'b1, 1'b0, "fix");
        check("fix_b_no_rvalid", {15'd0, b_rv}, 16'd0);

        // conflict on bank 2, round-robin
        sel = 2'd1;
        go(1'b1, 1'b0, "rr0"); check("rr0_a_rvalid", {15'd0, a_rv}, 16'd1);
        go(1'b0, 1'b1, "rr1"); check("rr1_b_rvalid", {15'd0, b_rv}, 16'd1);
        go(1'b1, 1'b0, "rr2"); check("rr2_a_rvalid", {15'd0, a_rv}, 16'd1);
        go(1'b0, 1'b1, "rr3"); check("rr3_b_rvalid", {15'd0, b_rv}, 16'd1);
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        setB(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);

        // power-down on the 3-bank instance: write bank 1, let it sleep, read back
        sel = 2'd2;
        @(negedge clock);
        setA(1'b1, 1'b1, 16'h4020, 16'hCAFE, 2'b11);
        #1;
        for (int k = 0; k < 10 && !a_rdy; k++) begin
            @(negedge clock);
            #1;
        end
        check("pd_wr_ready", {15'd0, a_rdy}, 16'd1);
        @(negedge clock);
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        repeat (7) @(negedge clock);
        check("pd_awake_7idle", {15'd0, if2.bank_awake[1]}, 16'd1);
        @(negedge clock);
        check("pd_asleep_8idle", {15'd0, if2.bank_awake[1]}, 16'd0);
        setA(1'b1, 1'b0, 16'h4020, 16'h0000, 2'b00);
        go(1'b0, 1'b0, "pd_w1");
        check("pd_waking", {15'd0, if2.bank_awake[1]}, 16'd0);
        go(1'b0, 1'b0, "pd_w2");
        go(1'b0, 1'b0, "pd_w3");
        go(1'b0, 1'b0, "pd_w4");
        go(1'b1, 1'b0, "pd_w5");
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        check("pd_rvalid", {15'd0, a_rv}, 16'd1);
        check("pd_data", a_rd, 16'hCAFE);

        // out-of-range bank 3 on the 3-bank instance
        setA(1'b1, 1'b1, 16'hC000, 16'h5555, 2'b11); go(1'b1, 1'b0, "oor_wr");
        check("oor_wr_no_rvalid", {15'd0, a_rv}, 16'd0);
        setA(1'b1, 1'b0, 16'hC000, 16'h0000, 2'b00); go(1'b1, 1'b0, "oor_rd");
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        check("oor_rvalid", {15'd0, a_rv}, 16'd1);
        check("oor_data", a_rd, 16'h0000);

        // reset during the rvalid cycle of a read
        sel = 2'd0;
        setA(1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00); go(1'b1, 1'b0, "rst_acc");
        reset_n = 1'b0;
        #1;
        check("rstm_a_rvalid", {15'd0, a_rv}, 16'd0);
        check("rstm_a_ready", {15'd0, a_rdy}, 16'd0);
        check("rstm_a_rdata", a_rd, 16'h0000);
        check("rstm_awake4", {12'd0, if0.bank_awake}, 16'h000F);
        check("rstm_awake3", {13'd0, if2.bank_awake}, 16'h0007);
        setA(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rstm_no_late_rvalid", {15'd0, a_rv}, 16'd0);
        check("rstm_rdata_after", a_rd, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
